// File: rtl/vga_sync_gen.sv
// VGA horizontal/vertical timing generator driven by a sampled divided pixel clock.
// The rising edge of dclk gives a one-clk pixel tick; all outputs are registered from next-state counts.
module vga_sync_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dclk,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic       dclk_q;
  logic       tick;
  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       video_on_q, video_on_d;
  logic       frame_start_q, frame_start_d;

  assign tick = dclk & ~dclk_q;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (tick) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  // Syncs and blanking come from the next-state counts so they land with the counters.
  always_comb begin
    hsync_d       = ((h_d >= HS_FIRST) && (h_d <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
    vsync_d       = ((v_d >= VS_FIRST) && (v_d <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
    video_on_d    = (h_d < H_VIS) && (v_d < V_VIS);
    frame_start_d = tick && (h_d == '0) && (v_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dclk_q        <= 1'b1;
      h_q           <= '0;
      v_q           <= '0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      video_on_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      dclk_q        <= dclk;
      frame_start_q <= frame_start_d;
      if (tick) begin
        h_q        <= h_d;
        v_q        <= v_d;
        hsync_q    <= hsync_d;
        vsync_q    <= vsync_d;
        video_on_q <= video_on_d;
      end
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign pixel_x     = h_q;
  assign pixel_y     = v_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: standard 640x480 instance plus a tiny-timing
// instance so a whole frame (vsync lines, frame_start) fits in a short run.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dclk = 1'b0;

  logic       hs_m, vs_m, von_m, fs_m;
  logic [9:0] x_m, y_m;
  logic       hs_s, vs_s, von_s, fs_s;
  logic [9:0] x_s, y_s;

  int  n_cmp = 0;
  int  n_bad = 0;
  bit  dclk_run = 1'b1;
  int  div_cnt = 0;
  logic dclk_p = 1'b1;
  logic tick_seen = 1'b0;
  int  fs_main = 0;
  int  fs_small = 0;
  int  low_cnt;
  int  yexp;

  always #5 clk = ~clk;

  // dclk = clk/4, changed on the falling edge so it is stable at every rising edge
  always @(negedge clk) begin
    if (dclk_run) begin
      div_cnt = div_cnt + 1;
      if (div_cnt == 2) begin
        div_cnt = 0;
        dclk = ~dclk;
      end
    end
  end

  vga_sync_gen u_dut (
    .clk(clk), .rst(rst), .dclk(dclk),
    .hsync(hs_m), .vsync(vs_m), .video_on(von_m),
    .pixel_x(x_m), .pixel_y(y_m), .frame_start(fs_m)
  );

  // 15 x 11 frame: vsync low on lines 7..8
  vga_sync_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .SYNC_POL(1'b0)
  ) u_small (
    .clk(clk), .rst(rst), .dclk(dclk),
    .hsync(hs_s), .vsync(vs_s), .video_on(von_s),
    .pixel_x(x_s), .pixel_y(y_s), .frame_start(fs_s)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic advance_clk();
    @(posedge clk);
    tick_seen = dclk & ~dclk_p;
    dclk_p = rst ? 1'b1 : dclk;
    #1;
    if (fs_m) fs_main = fs_main + 1;
    if (fs_s) fs_small = fs_small + 1;
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      int guard = 0;
      do begin
        advance_clk();
        guard = guard + 1;
      end while (!tick_seen && guard < 64);
      if (!tick_seen) check_eq("tick_timeout", 32'd0, 32'd1);
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) advance_clk();
    check_eq("rst_x", x_m, 0);
    check_eq("rst_y", y_m, 0);
    check_eq("rst_hsync", hs_m, 1);
    check_eq("rst_vsync", vs_m, 1);
    check_eq("rst_video_on", von_m, 0);
    check_eq("rst_frame_start", fs_m, 0);

    rst = 1'b0;
    run_ticks(1);
    check_eq("first_x", x_m, 1);
    check_eq("first_y", y_m, 0);
    check_eq("first_video_on", von_m, 1);

    run_ticks(638);
    check_eq("x639", x_m, 639);
    check_eq("x639_video_on", von_m, 1);
    check_eq("x639_hsync", hs_m, 1);

    run_ticks(1);
    check_eq("x640", x_m, 640);
    check_eq("x640_video_on", von_m, 0);
    check_eq("x640_hsync", hs_m, 1);

    run_ticks(15);
    check_eq("x655_hsync", hs_m, 1);
    run_ticks(1);
    check_eq("x656", x_m, 656);
    check_eq("x656_hsync", hs_m, 0);
    low_cnt = 1;
    for (int i = 0; i < 96; i++) begin
      run_ticks(1);
      if (hs_m == 1'b0) low_cnt = low_cnt + 1;
    end
    check_eq("hsync_low_width", low_cnt, 96);
    check_eq("x752", x_m, 752);
    check_eq("x752_hsync", hs_m, 1);

    // 5*800+799 - 752 ticks to reach (799,5)
    run_ticks(4047);
    check_eq("line_end_x", x_m, 799);
    check_eq("line_end_y", y_m, 5);
    run_ticks(1);
    check_eq("line_wrap_x", x_m, 0);
    check_eq("line_wrap_y", y_m, 6);
    check_eq("line_wrap_fs", fs_m, 0);
    check_eq("line_wrap_vsync", vs_m, 1);

    dclk_run = 1'b0;
    dclk = 1'b0;
    repeat (2) advance_clk();
    dclk = 1'b1;
    repeat (50) advance_clk();
    check_eq("hold_x", x_m, 1);
    check_eq("hold_y", y_m, 6);
    div_cnt = 0;
    dclk_run = 1'b1;

    run_ticks(299);
    check_eq("x300", x_m, 300);
    rst = 1'b1;
    advance_clk();
    check_eq("midrst_x", x_m, 0);
    check_eq("midrst_y", y_m, 0);
    check_eq("midrst_hsync", hs_m, 1);
    check_eq("midrst_vsync", vs_m, 1);
    check_eq("midrst_video_on", von_m, 0);
    rst = 1'b0;

    run_ticks(700);
    check_eq("x700", x_m, 700);
    check_eq("x700_hsync", hs_m, 0);
    rst = 1'b1;
    advance_clk();
    check_eq("syncrst_x", x_m, 0);
    check_eq("syncrst_hsync", hs_m, 1);
    rst = 1'b0;

    // full frame on the small instance
    fs_small = 0;
    for (int k = 1; k <= 165; k++) begin
      run_ticks(1);
      yexp = (k % 165) / 15;
      check_eq("s_vsync", vs_s, (yexp == 7 || yexp == 8) ? 0 : 1);
      check_eq("s_frame_start", fs_s, (k == 165) ? 1 : 0);
    end
    check_eq("s_wrap_x", x_s, 0);
    check_eq("s_wrap_y", y_s, 0);
    advance_clk();
    check_eq("s_fs_cleared", fs_s, 0);
    check_eq("s_fs_pulse_count", fs_small, 1);
    check_eq("m_fs_count", fs_main, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
